// File: rtl/cic_pkg.sv
// Constants shared by the PDM CIC decimator and interpolator tiles, so both agree
// on ratio, stage count and register widths, plus the uo_out bit map.
package cic_pkg;
   localparam int STAGES     = 2;
   localparam int UPSAMPLING = 4;
   localparam int WIDTH_CTR  = 2;
   localparam int WIDTH_IN   = 6;
   localparam int WIDTH_REGS = WIDTH_IN + (STAGES - 1) * WIDTH_CTR;

   localparam int UO_PDM     = 0;
   localparam int UO_STROBE  = 1;
   localparam int UO_DBG_LSB = 2;
   localparam int UO_DBG_MSB = 7;
   localparam int WIDTH_DBG  = UO_DBG_MSB - UO_DBG_LSB + 1;

   typedef logic [WIDTH_REGS-1:0] reg_t;
   typedef logic [WIDTH_CTR-1:0]  ctr_t;
endpackage

// File: rtl/cic_pdm_interpolator_sd.sv
// First-order sigma-delta modulator: unsigned accumulator whose registered carry
// is the 1-bit output, so ones density = din / 2^WIDTH.
module sd_modulator_1st #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic             pdm
);
   logic [WIDTH-1:0] acc;
   logic [WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, din};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         pdm <= 1'b0;
      end else begin
         {pdm, acc} <= sum;
      end
   end
endmodule

// File: rtl/cic_pdm_interpolator.sv
// CIC interpolator (combs at the input rate, integrators at the output rate)
// feeding a first-order sigma-delta modulator that produces a PDM bitstream.
module cic_pdm_interpolator
   import cic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out
);
   ctr_t ctr;
   logic strobe;
   reg_t sample_ext;
   reg_t comb_in  [STAGES];
   reg_t comb_buf [STAGES];
   reg_t comb_last;
   reg_t stuff_reg;
   reg_t integ    [STAGES];
   reg_t int_last;
   logic pdm_q;
   logic unused_bits;

   assign unused_bits = &{1'b0, ui_in[7:WIDTH_IN]};
   assign strobe      = (ctr == ctr_t'(UPSAMPLING - 1));
   assign sample_ext  = reg_t'(ui_in[WIDTH_IN-1:0]);
   assign int_last    = integ[STAGES-1];

   // Comb chain is purely combinational; only its delay buffers are registered.
   always_comb begin
      reg_t c;
      c = sample_ext;
      for (int j = 0; j < STAGES; j++) begin
         comb_in[j] = c;
         c = c - comb_buf[j];
      end
      comb_last = c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr       <= '0;
         stuff_reg <= '0;
         for (int j = 0; j < STAGES; j++) begin
            comb_buf[j] <= '0;
            integ[j]    <= '0;
         end
      end else begin
         ctr       <= ctr + ctr_t'(1);
         stuff_reg <= strobe ? comb_last : '0;
         if (strobe) begin
            for (int j = 0; j < STAGES; j++) begin
               comb_buf[j] <= comb_in[j];
            end
         end
         // Pipelined integrators: each stage sees the previous stage's pre-edge value.
         integ[0] <= integ[0] + stuff_reg;
         for (int i = 1; i < STAGES; i++) begin
            integ[i] <= integ[i] + integ[i-1];
         end
      end
   end

   sd_modulator_1st #(.WIDTH(WIDTH_REGS)) u_sd (
      .clk (clk),
      .rst (rst),
      .din (int_last),
      .pdm (pdm_q)
   );

   always_comb begin
      uo_out                        = '0;
      uo_out[UO_PDM]                = pdm_q;
      uo_out[UO_STROBE]             = strobe;
      uo_out[UO_DBG_MSB:UO_DBG_LSB] = int_last[WIDTH_REGS-1 -: WIDTH_DBG];
   end
endmodule

// File: tb/tb_cic_pdm_interpolator.sv
// Scoreboard bench: an impulse-response convolution model predicts uo_out each
// cycle; directed runs check reset timing, ones densities and the impulse trace.
module tb_cic_pdm_interpolator;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ui_in = 8'd0;
   logic [7:0] uo_out;

   int total = 0;
   int bad   = 0;

   int         xs[$];
   logic [7:0] exp_q[$];
   int         acc_m   = 0;
   int         il_prev = 0;
   int         h[7]    = '{1, 2, 3, 4, 3, 2, 1};

   cic_pdm_interpolator dut (
      .clk    (clk),
      .rst    (rst),
      .ui_in  (ui_in),
      .uo_out (uo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: samples taken every 4th edge, int_last is their convolution with
   // the triangular response, pdm is the carry of an 8-bit running sum.
   always @(posedge clk or posedge rst) begin : model
      int e, s, il, pdm, idx;
      if (rst) begin
         xs.delete();
         exp_q.delete();
         acc_m   = 0;
         il_prev = 0;
      end else begin
         e = xs.size();
         xs.push_back((e % 4 == 3) ? int'(ui_in[5:0]) : 0);
         s     = acc_m + il_prev;
         pdm   = (s >= 256) ? 1 : 0;
         acc_m = s % 256;
         il = 0;
         for (int d = 0; d < 7; d++) begin
            idx = e - 2 - d;
            if (idx >= 0) il += xs[idx] * h[d];
         end
         il = il % 256;
         il_prev = il;
         exp_q.push_back({il[7:2], (e % 4 == 2) ? 1'b1 : 1'b0, pdm[0]});
      end
   end

   always @(negedge clk) begin : monitor
      logic [7:0] ev;
      if (!rst && exp_q.size() > 0) begin
         ev = exp_q.pop_front();
         chk("scoreboard_uo_out", int'(uo_out), int'(ev));
      end
   end

   task automatic do_reset();
      int n, m;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("uo_out_in_reset", int'(uo_out), 0);
      repeat (2) @(negedge clk);
      chk("uo_out_held_reset", int'(uo_out), 0);
      rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!uo_out[1] && n < 8);
      chk("first_strobe_delay", n, 3);
      m = 0;
      do begin @(negedge clk); m++; end while (!uo_out[1] && m < 8);
      chk("strobe_period", m, 4);
   endtask

   // mode 0: constant val; 1: val on strobe cycles, random otherwise; 2: random
   task automatic drive_count(input int mode, input int val, input int n, output int ones);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ones += int'(uo_out[0]);
         case (mode)
            0:       ui_in = 8'(val);
            1:       ui_in = uo_out[1] ? 8'(val) : 8'($urandom_range(0, 255));
            default: ui_in = 8'($urandom_range(0, 255));
         endcase
      end
   endtask

   task automatic const_run(input string name, input int mode, input int val,
                            input int req_ones, input int req_dbg);
      int ones;
      ui_in = 8'(val);
      do_reset();
      drive_count(mode, val, 40, ones);
      drive_count(mode, val, 256, ones);
      chk({name, "_ones"}, ones, req_ones);
      chk({name, "_debug"}, int'(uo_out[7:2]), req_dbg);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int ones;
      int trace[10] = '{0, 0, 4, 8, 12, 16, 12, 8, 4, 0};

      const_run("zero",      0,  0,   0,  0);
      const_run("mid",       0, 32, 128, 32);
      const_run("full",      0, 63, 252, 63);
      const_run("handshake", 1, 40, 160, 40);

      // Impulse: do_reset returns during a strobe cycle.
      ui_in = 8'd0;
      do_reset();
      ui_in = 8'd16;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         ui_in = 8'd0;
         chk($sformatf("impulse_trace_%0d", k), int'(uo_out[7:2]), trace[k]);
      end
      drive_count(0, 0, 12, ones);
      chk("impulse_settles_zero", int'(uo_out[7:2]), 0);

      ui_in = 8'd16;
      do_reset();
      drive_count(0, 16, 40, ones);
      chk("step16_debug", int'(uo_out[7:2]), 16);

      ui_in = 8'($urandom_range(0, 255));
      do_reset();
      drive_count(2, 0, 301, ones);
      #2 rst = 1'b1;
      #1 chk("mid_frame_reset", int'(uo_out), 0);
      @(negedge clk);
      rst = 1'b0;
      drive_count(2, 0, 300, ones);
      @(negedge clk);
      chk("scoreboard_drained", (exp_q.size() <= 1) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cic_pdm_interpolator.md
Name: cic_pdm_interpolator

Overview:
- CIC interpolator followed by a first-order sigma-delta modulator. Turns a low-rate multi-bit sample stream into a 1-bit PDM bitstream.
- Transmit-side counterpart of the team's PDM-input CIC decimator: its output bitstream can drive a PDM DAC or loop back into the decimator.
- Sits in a micro tile: samples arrive on ui_in, the PDM bit and the sample-request strobe leave on uo_out.

Parameters:
- STAGES, 2, number of comb stages and number of integrator stages.
- UPSAMPLING, 4, interpolation ratio R; must be a power of two, at least 2.
- WIDTH_CTR, 2, log2(UPSAMPLING).
- WIDTH_IN, 6, input sample width, unsigned.
- WIDTH_REGS, WIDTH_IN + (STAGES-1)*WIDTH_CTR (=8), width of every comb and integrator register.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ui_in  input  8  [WIDTH_IN-1:0] sample (unsigned); remaining bits ignored.
- uo_out  output  8  [0] pdm_out; [1] sample_strobe; [7:2] int_last[WIDTH_REGS-1:WIDTH_REGS-6] (debug).

Behaviour:
- Reset: asserting rst clears ctr, all comb buffers, stuff_reg, all integrators, sigma-delta acc and pdm_q to 0 immediately. uo_out = 0 during reset. Reset mid-frame discards the partial frame; after release, ctr restarts at 0.
- Phase counter ctr, WIDTH_CTR bits, counts 0..R-1 and wraps.
- sample_strobe = (ctr == R-1), a decode of the ctr register. It is high for exactly one cycle in every R cycles. The first strobe occurs R-1 cycles after reset release.
- Handshake: the driver must hold ui_in stable through any cycle in which sample_strobe is high. The sample is consumed on the rising edge that ends that cycle. Values on ui_in at all other edges are ignored.
- Comb chain: combinational. comb_in[0] = zero-extended sample; comb_out[j] = comb_in[j] - comb_buf[j]; comb_in[j] = comb_out[j-1].
  - comb_buf[j] <= comb_in[j] only on strobe edges.
  - All arithmetic is modulo 2^WIDTH_REGS (two's-complement wrap, no saturation).
- Zero stuffing: stuff_reg <= comb_out[STAGES-1] on a strobe edge, else 0.
- Integrators: pipelined, updated every edge. int[0] <= int[0] + stuff_reg; int[i] <= int[i] + int[i-1]. Arithmetic is modulo 2^WIDTH_REGS.
  - The impulse response is non-negative, with DC gain R^(STAGES-1) (=4).
  - int_last therefore stays within 0..(2^WIDTH_IN - 1)*4 = 252 and never wraps in the final value.
- Sigma-delta: {pdm_q, acc} <= acc + int_last, computed as a WIDTH_REGS+1 bit sum; pdm_out = pdm_q (registered carry).
  - Long-run ones density = int_last / 2^WIDTH_REGS, which equals sample / 2^WIDTH_IN at DC.
- Latency (STAGES=2), for a sample consumed at edge E:
  - stuff_reg updates at E.
  - int[0] at E+1, int[1] at E+2.
  - First influence on pdm_out at E+3.
- Simultaneous events: none beyond strobe vs. integrator update. Both occur on the same edge and use pre-edge values.

Decomposition:
- Shared package holds:
  - cic_pkg constants: STAGES, UPSAMPLING, WIDTH_CTR, WIDTH_REGS, so the decimator and interpolator agree on ratio and stage count.
  - the uo_out bit-index constants.
- One natural sub-module: sd_modulator_1st (accumulator + carry output, WIDTH_REGS parameter), reusable by other DAC tiles.
- Comb and integrator chains stay as generate loops in the top.

Test Plan:
- Reset: hold rst high, then release. Required:
  - uo_out = 0 while rst is high.
  - sample_strobe first high exactly 3 cycles after release, then every 4th cycle.
  - Asserting rst mid-frame zeroes uo_out within the same cycle, with no clock edge needed.
- Zero input: ui_in = 0 for 256 cycles -> pdm_out = 0 on every cycle; debug bits = 0.
- Mid-scale: ui_in = 32 constant. Required:
  - int_last settles at 128 (debug = 32).
  - pdm_out strictly alternates 0,1 once settled: exactly 128 ones in 256 cycles.
- Full-scale: ui_in = 63 constant -> int_last settles at 252; pdm_out has exactly 252 ones in every 256-cycle window after settling.
- Impulse/step: sample 16 presented once, zeros elsewhere. Required:
  - int_last traces 16 × {1,2,3,4,3,2,1} on consecutive cycles, starting 2 edges after the strobe edge, then returns to 0.
  - A held step of 16 settles at int_last = 64.
- Handshake: toggle ui_in randomly on non-strobe cycles, constant 40 on strobe cycles -> output identical to a constant-40 run (160 ones per 256 cycles after settling).
